// File: rtl/board_pkg.sv
// board_pkg: shared FSM encoding, square helpers and history field widths
package board_pkg;
  typedef enum logic [2:0] {SEL_FROM, SEL_TO, CHECK, APPLY, UNDO} state_t;
  localparam int HIST_FIELDS = 4;
  function automatic logic sq_owner(input logic [31:0] sq, input int pw);
    return sq[pw-1];
  endfunction
  function automatic logic sq_empty(input logic [31:0] sq);
    return sq == 32'd0;
  endfunction
  function automatic int hist_w(input int sw, input int pw);
    return 2 * sw + 2 * pw;
  endfunction
endpackage

// File: rtl/board_hist.sv
// board_hist: circular LIFO of move records, oldest entry overwritten when full
module board_hist #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  assign dout = mem[ptr - 1'b1];
  // write pointer and saturating entry count
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ptr <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      count <= (count == (AW+1)'(DEPTH)) ? count : count + 1'b1;
    end else if (pop && count != '0) begin
      ptr <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  // entry storage needs no reset; only entries counted as valid are ever read
  always_ff @(posedge clk)
    if (push) mem[ptr] <= din;
endmodule

// File: rtl/board_ctrl_p.sv
// board_ctrl_p: cursor/selection FSM that applies checker-approved moves with undo
module board_ctrl_p
  import board_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int PW = 4,
  parameter int HIST_DEPTH = 16,
  parameter logic [ROWS*COLS*PW-1:0] INIT = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              BTNC,
  input  logic                              BTNU,
  input  logic                              BTND,
  input  logic                              BTNL,
  input  logic                              BTNR,
  input  logic                              BTNZ,
  input  logic                              legal_ack,
  input  logic                              legal_ok,
  output logic [ROWS*COLS*PW-1:0]           board,
  output logic [$clog2(ROWS*COLS)-1:0]      cursor,
  output logic [2*$clog2(ROWS*COLS):0]      moveData,
  output logic                              check_req,
  output logic                              led,
  output logic [$clog2(HIST_DEPTH):0]       hist_count
);
  localparam int SW = $clog2(ROWS*COLS);
  localparam int EW = hist_w(SW, PW);
  state_t state, state_n;
  logic [SW-1:0] from, to, cursor_n, from_n, to_n;
  logic [SW-1:0] cur_up, cur_dn, cur_lt, cur_rt, hf, ht;
  logic [PW-1:0] cur_sq, hm, hc;
  logic [ROWS*COLS*PW-1:0] board_n;
  logic [EW-1:0] hdin, hdout;
  logic turn, turn_n, own, push, pop;
  int row, col;
  assign cur_sq = board[cursor*PW +: PW];
  assign own = !sq_empty(32'(cur_sq)) && sq_owner(32'(cur_sq), PW) == turn;
  assign row = int'(cursor) / COLS;
  assign col = int'(cursor) % COLS;
  assign cur_up = SW'((row == 0 ? ROWS-1 : row-1) * COLS + col);
  assign cur_dn = SW'((row == ROWS-1 ? 0 : row+1) * COLS + col);
  assign cur_lt = SW'(row * COLS + (col == 0 ? COLS-1 : col-1));
  assign cur_rt = SW'(row * COLS + (col == COLS-1 ? 0 : col+1));
  assign hdin = {from, to, board[from*PW +: PW], board[to*PW +: PW]};
  assign {hf, ht, hm, hc} = hdout;
  assign moveData = {turn, from, to};
  assign led = turn;
  board_hist #(.DEPTH(HIST_DEPTH), .W(EW)) u_hist (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din(hdin), .dout(hdout), .count(hist_count)
  );
  // next state, selection latches and board edits; one button acts per cycle
  always_comb begin
    state_n = state;
    cursor_n = cursor;
    from_n = from;
    to_n = to;
    turn_n = turn;
    board_n = board;
    push = 1'b0;
    pop = 1'b0;
    case (state)
      SEL_FROM, SEL_TO:
        if (BTNC) begin
          if (state == SEL_FROM) begin
            if (own) begin
              from_n = cursor;
              state_n = SEL_TO;
            end
          end else if (cursor == from) state_n = SEL_FROM;
          else if (own) from_n = cursor;
          else begin
            to_n = cursor;
            state_n = CHECK;
          end
        end else if (BTNZ) state_n = (state == SEL_TO) ? SEL_FROM : (hist_count != '0 ? UNDO : SEL_FROM);
        else if (BTNU) cursor_n = cur_up;
        else if (BTND) cursor_n = cur_dn;
        else if (BTNL) cursor_n = cur_lt;
        else if (BTNR) cursor_n = cur_rt;
      CHECK:
        if (legal_ack) state_n = legal_ok ? APPLY : SEL_FROM;
      APPLY: begin
        board_n[to*PW +: PW] = board[from*PW +: PW];
        board_n[from*PW +: PW] = '0;
        push = 1'b1;
        turn_n = !turn;
        state_n = SEL_FROM;
      end
      UNDO: begin
        board_n[hf*PW +: PW] = hm;
        board_n[ht*PW +: PW] = hc;
        pop = 1'b1;
        turn_n = !turn;
        state_n = SEL_FROM;
      end
      default: state_n = SEL_FROM;
    endcase
  end
  // state registers; check_req is high exactly while the FSM sits in CHECK
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= SEL_FROM;
      board <= INIT;
      cursor <= '0;
      from <= '0;
      to <= '0;
      turn <= 1'b0;
      check_req <= 1'b0;
    end else begin
      state <= state_n;
      board <= board_n;
      cursor <= cursor_n;
      from <= from_n;
      to <= to_n;
      turn <= turn_n;
      check_req <= (state_n == CHECK);
    end
endmodule

// File: tb/tb_board_ctrl_p.sv
// tb_board_ctrl_p: directed scenario tests for board_ctrl_p on an 8x8 board
module tb_board_ctrl_p;
  localparam logic [255:0] INIT_B = (256'h1 << 48) | (256'h9 << 112);
  logic clk = 1'b0, reset = 1'b0;
  logic BTNC = 0, BTNU = 0, BTND = 0, BTNL = 0, BTNR = 0, BTNZ = 0;
  logic legal_ack = 0, legal_ok = 0;
  logic [255:0] board;
  logic [5:0] cursor;
  logic [12:0] moveData;
  logic check_req, led;
  logic [2:0] hist_count;
  int tests = 0, fails = 0, cur_m = 0;
  board_ctrl_p #(.ROWS(8), .COLS(8), .PW(4), .HIST_DEPTH(4), .INIT(INIT_B)) dut (
    .clk(clk), .reset(reset), .BTNC(BTNC), .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL),
    .BTNR(BTNR), .BTNZ(BTNZ), .legal_ack(legal_ack), .legal_ok(legal_ok), .board(board),
    .cursor(cursor), .moveData(moveData), .check_req(check_req), .led(led), .hist_count(hist_count)
  );
  always #5 clk = ~clk;
  function automatic logic [255:0] setsq(input logic [255:0] b, input int i, input logic [3:0] v);
    logic [255:0] r;
    r = b;
    r[i*4 +: 4] = v;
    return r;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cur_m = 0;
  endtask
  task automatic press(input int b);
    {BTNC, BTNZ, BTNU, BTND, BTNL, BTNR} = 6'b100000 >> b;
    @(negedge clk);
    {BTNC, BTNZ, BTNU, BTND, BTNL, BTNR} = '0;
    case (b)
      2: cur_m = ((cur_m / 8 + 7) % 8) * 8 + cur_m % 8;
      3: cur_m = ((cur_m / 8 + 1) % 8) * 8 + cur_m % 8;
      4: cur_m = (cur_m / 8) * 8 + (cur_m % 8 + 7) % 8;
      5: cur_m = (cur_m / 8) * 8 + (cur_m % 8 + 1) % 8;
      default: ;
    endcase
  endtask
  task automatic goto_sq(input int t);
    while (cur_m / 8 != t / 8) press(3);
    while (cur_m % 8 != t % 8) press(5);
  endtask
  task automatic do_move(input int f, input int t, input logic ok);
    int n;
    goto_sq(f);
    press(0);
    goto_sq(t);
    press(0);
    n = 0;
    while (!check_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (check_req !== 1'b1) begin
      fails++;
      $display("FAIL check_req_wait %0d->%0d: got %b expected 1", f, t, check_req);
    end
    legal_ack = 1'b1;
    legal_ok = ok;
    @(negedge clk);
    legal_ack = 1'b0;
    legal_ok = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    do_reset();
    tests += 5;
    if (board !== INIT_B) begin fails++; $display("FAIL reset_board: got %h expected %h", board, INIT_B); end
    if (cursor !== 6'd0) begin fails++; $display("FAIL reset_cursor: got %0d expected 0", cursor); end
    if (check_req !== 1'b0) begin fails++; $display("FAIL reset_check_req: got %b expected 0", check_req); end
    if (hist_count !== 3'd0) begin fails++; $display("FAIL reset_hist: got %0d expected 0", hist_count); end
    if (moveData !== 13'd0 || led !== 1'b0) begin fails++; $display("FAIL reset_move_led: got %h/%b expected 0/0", moveData, led); end
    press(5);
    tests++;
    if (cursor !== 6'd1) begin fails++; $display("FAIL first_button: got %0d expected 1", cursor); end
  endtask
  task automatic test_cursor();
    do_reset();
    repeat (7) press(4);
    tests++;
    if (cursor !== 6'd1) begin fails++; $display("FAIL left_wrap: got %0d expected 1", cursor); end
    do_reset();
    press(2);
    tests++;
    if (cursor !== 6'd56) begin fails++; $display("FAIL up_wrap: got %0d expected 56", cursor); end
    press(3);
    tests++;
    if (cursor !== 6'd0) begin fails++; $display("FAIL down_wrap: got %0d expected 0", cursor); end
    press(4);
    tests++;
    if (cursor !== 6'd7) begin fails++; $display("FAIL left_row_wrap: got %0d expected 7", cursor); end
    press(5);
    tests++;
    if (cursor !== 6'd0) begin fails++; $display("FAIL right_row_wrap: got %0d expected 0", cursor); end
    {BTNU, BTNR} = 2'b11;
    @(negedge clk);
    {BTNU, BTNR} = 2'b00;
    tests++;
    if (cursor !== 6'd56) begin fails++; $display("FAIL priority_u_over_r: got %0d expected 56", cursor); end
  endtask
  task automatic test_move();
    logic [255:0] exp;
    do_reset();
    do_move(12, 28, 1'b1);
    exp = setsq(setsq(INIT_B, 12, 4'h0), 28, 4'h1);
    tests += 4;
    if (board !== exp) begin fails++; $display("FAIL move_board: got %h expected %h", board, exp); end
    if (led !== 1'b1) begin fails++; $display("FAIL move_turn: got %b expected 1", led); end
    if (hist_count !== 3'd1) begin fails++; $display("FAIL move_hist: got %0d expected 1", hist_count); end
    if (moveData !== {1'b1, 6'd12, 6'd28}) begin fails++; $display("FAIL move_data: got %h expected %h", moveData, {1'b1, 6'd12, 6'd28}); end
  endtask
  task automatic test_reject();
    do_reset();
    do_move(12, 28, 1'b0);
    tests += 3;
    if (board !== INIT_B) begin fails++; $display("FAIL reject_board: got %h expected %h", board, INIT_B); end
    if (led !== 1'b0) begin fails++; $display("FAIL reject_turn: got %b expected 0", led); end
    if (check_req !== 1'b0) begin fails++; $display("FAIL reject_check_req: got %b expected 0", check_req); end
    press(5);
    tests++;
    if (cursor !== 6'd29) begin fails++; $display("FAIL reject_sel_from: got %0d expected 29", cursor); end
  endtask
  task automatic test_opponent_select();
    do_reset();
    goto_sq(28);
    press(0);
    goto_sq(29);
    press(0);
    repeat (2) @(negedge clk);
    tests++;
    if (check_req !== 1'b0) begin fails++; $display("FAIL opponent_select: got %b expected 0", check_req); end
  endtask
  task automatic test_capture_undo();
    do_reset();
    do_move(12, 28, 1'b1);
    press(1);
    @(negedge clk);
    tests += 3;
    if (board !== INIT_B) begin fails++; $display("FAIL undo_board: got %h expected %h", board, INIT_B); end
    if (led !== 1'b0) begin fails++; $display("FAIL undo_turn: got %b expected 0", led); end
    if (hist_count !== 3'd0) begin fails++; $display("FAIL undo_hist: got %0d expected 0", hist_count); end
  endtask
  task automatic test_history();
    logic [255:0] exp;
    do_reset();
    do_move(12, 13, 1'b1);
    do_move(28, 29, 1'b1);
    do_move(13, 14, 1'b1);
    do_move(29, 30, 1'b1);
    do_move(14, 15, 1'b1);
    exp = setsq(setsq(256'h0, 15, 4'h1), 30, 4'h9);
    tests += 3;
    if (hist_count !== 3'd4) begin fails++; $display("FAIL hist_full: got %0d expected 4", hist_count); end
    if (board !== exp) begin fails++; $display("FAIL hist_board: got %h expected %h", board, exp); end
    if (led !== 1'b1) begin fails++; $display("FAIL hist_turn: got %b expected 1", led); end
    repeat (4) begin
      press(1);
      @(negedge clk);
    end
    exp = setsq(setsq(256'h0, 13, 4'h1), 28, 4'h9);
    tests += 3;
    if (hist_count !== 3'd0) begin fails++; $display("FAIL hist_empty: got %0d expected 0", hist_count); end
    if (board !== exp) begin fails++; $display("FAIL hist_restore: got %h expected %h", board, exp); end
    if (led !== 1'b1) begin fails++; $display("FAIL hist_restore_turn: got %b expected 1", led); end
    press(1);
    @(negedge clk);
    tests += 2;
    if (board !== exp || hist_count !== 3'd0) begin fails++; $display("FAIL fifth_undo: got %h/%0d expected %h/0", board, hist_count, exp); end
    if (led !== 1'b1) begin fails++; $display("FAIL fifth_undo_turn: got %b expected 1", led); end
  endtask
  task automatic test_reset_mid_check();
    int n;
    do_reset();
    goto_sq(12);
    press(0);
    goto_sq(20);
    press(0);
    n = 0;
    while (!check_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (check_req !== 1'b1) begin fails++; $display("FAIL mid_check_req: got %b expected 1", check_req); end
    #2 reset = 1'b0;
    #1;
    tests += 3;
    if (board !== INIT_B) begin fails++; $display("FAIL async_board: got %h expected %h", board, INIT_B); end
    if (check_req !== 1'b0) begin fails++; $display("FAIL async_check_req: got %b expected 0", check_req); end
    if (cursor !== 6'd0) begin fails++; $display("FAIL async_cursor: got %0d expected 0", cursor); end
    @(negedge clk);
    reset = 1'b1;
    cur_m = 0;
    legal_ack = 1'b1;
    legal_ok = 1'b1;
    @(negedge clk);
    legal_ack = 1'b0;
    legal_ok = 1'b0;
    repeat (2) @(negedge clk);
    tests += 2;
    if (board !== INIT_B || led !== 1'b0) begin fails++; $display("FAIL late_ack_board: got %h/%b expected %h/0", board, led, INIT_B); end
    if (hist_count !== 3'd0) begin fails++; $display("FAIL late_ack_hist: got %0d expected 0", hist_count); end
  endtask
  initial begin
    test_reset();
    test_cursor();
    test_move();
    test_reject();
    test_opponent_select();
    test_capture_undo();
    test_history();
    test_reset_mid_check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/board_ctrl_p.md
BOARD_CTRL_P -- requirements
Module: board_ctrl_p

Interface
REQ-001 SHALL have parameter ROWS, default 8, board rows.
REQ-002 SHALL have parameter COLS, default 8, board columns.
REQ-003 SHALL have parameter PW, default 4, bits per square; value 0 is empty, MSB is owner (0 = player 0).
REQ-004 SHALL have parameter HIST_DEPTH, default 16, undo history entries (power of 2, at least 2).
REQ-005 SHALL have parameter INIT, default all-zero, ROWS*COLS*PW-bit start position.
REQ-006 SHALL define SW = clog2(ROWS*COLS); square index = row*COLS+col; square s occupies board[s*PW +: PW].
REQ-007 clk  in  1  single system clock; all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 BTNC, BTNU, BTND, BTNL, BTNR, BTNZ  in  1 each  one-cycle debounced pulses (select, up, down, left, right, undo).
REQ-010 legal_ack  in  1  checker response strobe; legal_ok  in  1  verdict, valid when legal_ack=1.
REQ-011 board  out  ROWS*COLS*PW  registered board state.
REQ-012 cursor  out  SW  current cursor square.
REQ-013 moveData  out  2*SW+1  {turn, from, to}.
REQ-014 check_req  out  1  legality request, level.
REQ-015 led  out  1  equals turn.
REQ-016 hist_count  out  clog2(HIST_DEPTH)+1  valid history entries.

Function
REQ-017 FSM states SHALL be SEL_FROM, SEL_TO, CHECK, APPLY, UNDO.
REQ-018 In SEL_FROM/SEL_TO, only the highest-priority pulse per cycle SHALL act: BTNC > BTNZ > BTNU > BTND > BTNL > BTNR.
REQ-019 Cursor moves SHALL take 1 cycle; up/down wrap within column, left/right wrap within row.
REQ-020 SEL_FROM + BTNC on a non-empty square owned by turn SHALL latch from=cursor and go to SEL_TO; otherwise no change.
REQ-021 SEL_TO + BTNC on cursor==from SHALL deselect to SEL_FROM; on a square owned by turn SHALL re-latch from; otherwise latch to=cursor and go to CHECK.
REQ-022 check_req SHALL assert the cycle after entering CHECK and hold until the cycle legal_ack is seen.
REQ-023 legal_ack with legal_ok=1 SHALL go to APPLY; legal_ok=0 SHALL return to SEL_FROM with board unchanged.
REQ-024 Buttons during CHECK, APPLY, UNDO SHALL be ignored; legal_ack outside CHECK SHALL be ignored.
REQ-025 APPLY (1 cycle) SHALL write board[to]=board[from], board[from]=0, push {from, to, moved, captured}, toggle turn, then go to SEL_FROM.
REQ-026 Full history push SHALL overwrite the oldest entry; hist_count saturates at HIST_DEPTH.
REQ-027 BTNZ in SEL_FROM with hist_count>0 SHALL enter UNDO; with hist_count=0 it SHALL be ignored. In SEL_TO it SHALL drop selection to SEL_FROM without undo.
REQ-028 UNDO (1 cycle) SHALL pop newest entry, restore board[from]=moved, board[to]=captured, toggle turn, decrement hist_count, go to SEL_FROM.
REQ-029 board, turn, hist_count SHALL change only in APPLY or UNDO.

Reset
REQ-030 reset low SHALL immediately force board=INIT, cursor=0, from=0, to=0, turn=0, check_req=0, hist_count=0, state SEL_FROM, including mid-CHECK.
REQ-031 After deassertion the first button SHALL be honoured on the next rising edge.

Structure
REQ-032 A shared package board_pkg SHALL hold state encodings, owner-bit and empty-code helpers, and history-entry field widths.
REQ-033 History SHALL be a sub-module board_hist: circular LIFO, push/pop, overwrite-on-full, count output.

Verification (ROWS=COLS=8, PW=4, HIST_DEPTH=4)
REQ-034 Reset, 7x BTNL -> cursor=1 (wrap 0->7->...->1); BTNU at 0 -> cursor=56.
REQ-035 Select 12 (piece 4'h1), BTNC at 28, legal_ack+legal_ok=1 -> board[28]=1, board[12]=0, turn=1, hist_count=1.
REQ-036 Same move, legal_ok=0 -> board unchanged, turn=0, state SEL_FROM, check_req low next cycle.
REQ-037 Capture 4'h9 at 28 by 4'h1, then BTNZ -> board[12]=1, board[28]=9, turn=0, hist_count=0.
REQ-038 Five legal moves -> hist_count=4; five BTNZ -> four restores, fifth ignored.
REQ-039 reset low while check_req=1 -> board=INIT, check_req=0 same time step; late legal_ack ignored.
